// File: rtl/mem_bus_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// mem_bus_arbiter_pkg
//   Shared definitions for the unified-memory arbiter: bus widths, FSM state
//   encoding, requester port identifiers and the write-enable "read" code.
//   No ports (package).
// -----------------------------------------------------------------------------
package mem_bus_arbiter_pkg;

   localparam int unsigned XLEN   = 32;   // data width
   localparam int unsigned AWIDTH = 12;   // address width

   typedef enum logic [1:0] {
      ARB_IDLE = 2'd0,
      ARB_BUSY = 2'd1,
      ARB_DONE = 2'd2
   } arb_state_e;

   // Port index doubles as the index into the per-port ack/rdata vectors.
   typedef enum logic [0:0] {
      ARB_PORT_IF = 1'b0,
      ARB_PORT_DM = 1'b1
   } arb_port_e;

   localparam int unsigned ARB_NPORTS = 2;

   localparam logic [2:0] WE_READ = 3'b000;

   // Width of a counter that must hold 0..maxval; never narrower than 1 bit
   // so a zero-valued parameter still elaborates.
   function automatic int unsigned cnt_width(input int unsigned maxval);
      return (maxval > 0) ? $clog2(maxval + 1) : 1;
   endfunction

endpackage

// File: rtl/mem_bus_arbiter_if.sv
// -----------------------------------------------------------------------------
// mem_bus_arbiter_if
//   Bundles the fetch port (if_*), data port (dm_*) and memory port (mem_*)
//   of the arbiter.
//   modport master : the arbiter itself (drives acks, rdata and the memory bus)
//   modport slave  : the environment (requesters and the memory)
// -----------------------------------------------------------------------------
interface mem_bus_arbiter_if;
   import mem_bus_arbiter_pkg::*;

   // fetch port
   logic              if_req;
   logic [AWIDTH-1:0] if_addr;
   logic [XLEN-1:0]   if_rdata;
   logic              if_ack;
   // data port
   logic              dm_req;
   logic [AWIDTH-1:0] dm_addr;
   logic [XLEN-1:0]   dm_wdata;
   logic [2:0]        dm_we;
   logic [XLEN-1:0]   dm_rdata;
   logic              dm_ack;
   logic              bus_err;
   // memory port
   logic              mem_req;
   logic [AWIDTH-1:0] mem_addr;
   logic [XLEN-1:0]   mem_wdata;
   logic [2:0]        mem_we;
   logic [XLEN-1:0]   mem_rdata;
   logic              mem_ready;

   modport master (
      input  if_req, if_addr, dm_req, dm_addr, dm_wdata, dm_we, mem_rdata, mem_ready,
      output if_rdata, if_ack, dm_rdata, dm_ack, bus_err, mem_req, mem_addr, mem_wdata, mem_we
   );

   modport slave (
      output if_req, if_addr, dm_req, dm_addr, dm_wdata, dm_we, mem_rdata, mem_ready,
      input  if_rdata, if_ack, dm_rdata, dm_ack, bus_err, mem_req, mem_addr, mem_wdata, mem_we
   );

endinterface

// File: rtl/mem_bus_arbiter_watchdog.sv
// -----------------------------------------------------------------------------
// mem_bus_arbiter_watchdog
//   Counts BUSY cycles without mem_ready and flags the cycle in which the
//   count would reach TIMEOUT_CYC. TIMEOUT_CYC = 0 disables it (hit_o = 0).
//   clk      in   clock
//   rst_n    in   asynchronous active-low reset
//   clear_i  in   reset the count to zero (held outside BUSY)
//   enable_i in   a BUSY cycle without mem_ready
//   hit_o    out  terminal cycle reached; only asserted while enable_i = 1
// -----------------------------------------------------------------------------
module mem_bus_arbiter_watchdog
   import mem_bus_arbiter_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYC = 64
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clear_i,
   input  logic enable_i,
   output logic hit_o
);

   localparam int unsigned CNT_W = cnt_width(TIMEOUT_CYC);

   if (TIMEOUT_CYC == 0) begin : g_off
      logic unused_inputs;
      assign unused_inputs = clk ^ rst_n ^ clear_i ^ enable_i;
      assign hit_o         = 1'b0;
   end else begin : g_on
      logic [CNT_W-1:0] cnt_q, cnt_d;
      logic             terminal;

      // The counter holds the number of stalled cycles already completed, so
      // the stalled cycle whose increment would reach TIMEOUT_CYC is the one
      // that forces completion. A mem_ready in that cycle drops enable_i and
      // therefore wins over the timeout.
      assign terminal = (cnt_q == CNT_W'(TIMEOUT_CYC - 1));
      assign hit_o    = enable_i && terminal;

      always_comb begin
         cnt_d = cnt_q;
         if (clear_i) begin
            cnt_d = '0;
         end else if (enable_i && !terminal) begin
            cnt_d = cnt_q + 1'b1;
         end
      end

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            cnt_q <= '0;
         end else begin
            cnt_q <= cnt_d;
         end
      end
   end

endmodule

// File: rtl/mem_bus_arbiter.sv
// -----------------------------------------------------------------------------
// mem_bus_arbiter
//   Shares one single-port memory between the fetch port and the data port.
//   A winner is chosen in IDLE, its request is registered onto the memory bus
//   for the whole BUSY state, and DONE returns a one-cycle ack (plus bus_err
//   if the watchdog forced completion). Data wins collisions unless it has
//   already been granted DM_STREAK_MAX times in a row while fetch waited.
//   clk     in   clock
//   rst_n   in   asynchronous active-low reset; aborts an access without ack
//   bus_io  master modport of mem_bus_arbiter_if (if_*, dm_*, mem_*, bus_err)
//   All outputs come straight from registers.
// -----------------------------------------------------------------------------
module mem_bus_arbiter
   import mem_bus_arbiter_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYC   = 64,
   parameter int unsigned DM_STREAK_MAX = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   mem_bus_arbiter_if.master bus_io
);

   localparam int unsigned STREAK_W = cnt_width(DM_STREAK_MAX);

   arb_state_e                      state_q, state_d;
   arb_port_e                       winner_q, winner_d;
   logic [STREAK_W-1:0]             streak_q, streak_d;
   logic [AWIDTH-1:0]               addr_q, addr_d;
   logic [XLEN-1:0]                 wdata_q, wdata_d;
   logic [2:0]                      we_q, we_d;
   logic                            mem_req_q, mem_req_d;
   logic                            err_q, err_d;

   logic                            wd_clear, wd_enable, wd_hit;
   logic                            finish_ok, finish_to;
   logic                            grant_if;
   logic [ARB_NPORTS-1:0]           port_ack;
   logic [ARB_NPORTS-1:0][XLEN-1:0] port_rdata;

   // ---------------------------------------------------------------- watchdog
   assign wd_clear  = (state_q != ARB_BUSY);
   assign wd_enable = (state_q == ARB_BUSY) && !bus_io.mem_ready;

   mem_bus_arbiter_watchdog #(
      .TIMEOUT_CYC (TIMEOUT_CYC)
   ) u_watchdog (
      .clk      (clk),
      .rst_n    (rst_n),
      .clear_i  (wd_clear),
      .enable_i (wd_enable),
      .hit_o    (wd_hit)
   );

   // mem_ready is only meaningful in BUSY; wd_hit already implies BUSY.
   assign finish_ok = (state_q == ARB_BUSY) && bus_io.mem_ready;
   assign finish_to = wd_hit;

   // Fetch wins only when data is absent or data has used up its streak.
   assign grant_if = bus_io.if_req &&
                     (!bus_io.dm_req || (streak_q == STREAK_W'(DM_STREAK_MAX)));

   // ------------------------------------------------------- FSM next state
   always_comb begin
      state_d  = state_q;
      winner_d = winner_q;
      streak_d = streak_q;
      addr_d   = addr_q;
      wdata_d  = wdata_q;
      we_d     = we_q;
      err_d    = 1'b0;

      case (state_q)
         ARB_IDLE: begin
            if (grant_if) begin
               state_d  = ARB_BUSY;
               winner_d = ARB_PORT_IF;
               addr_d   = bus_io.if_addr;
               wdata_d  = '0;
               we_d     = WE_READ;
               streak_d = '0;
            end else if (bus_io.dm_req) begin
               state_d  = ARB_BUSY;
               winner_d = ARB_PORT_DM;
               addr_d   = bus_io.dm_addr;
               wdata_d  = bus_io.dm_wdata;
               we_d     = bus_io.dm_we;
               // Only grants that actually made fetch wait extend the streak.
               streak_d = bus_io.if_req ? streak_q + 1'b1 : '0;
            end
         end
         ARB_BUSY: begin
            if (finish_ok) begin
               state_d = ARB_DONE;
            end else if (finish_to) begin
               state_d = ARB_DONE;
               err_d   = 1'b1;
            end
         end
         ARB_DONE: begin
            state_d = ARB_IDLE;
         end
         default: begin
            state_d = ARB_IDLE;
         end
      endcase

      mem_req_d = (state_d == ARB_BUSY);
   end

   // ------------------------------------------------------- FSM registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ARB_IDLE;
         winner_q  <= ARB_PORT_IF;
         streak_q  <= '0;
         addr_q    <= '0;
         wdata_q   <= '0;
         we_q      <= WE_READ;
         mem_req_q <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         winner_q  <= winner_d;
         streak_q  <= streak_d;
         addr_q    <= addr_d;
         wdata_q   <= wdata_d;
         we_q      <= we_d;
         mem_req_q <= mem_req_d;
         err_q     <= err_d;
      end
   end

   // ------------------------------------------------ per-port ack and rdata
   // Each port owns its ack pulse and read-data register; only the winner of
   // the finishing access touches its own pair, and writes leave rdata alone.
   for (genvar gi = 0; gi < ARB_NPORTS; gi++) begin : g_port
      logic            sel;
      logic            ack_q, ack_d;
      logic [XLEN-1:0] rdata_q, rdata_d;

      assign sel = (int'(winner_q) == gi);

      always_comb begin
         ack_d   = 1'b0;
         rdata_d = rdata_q;
         if (sel && (finish_ok || finish_to)) begin
            ack_d = 1'b1;
            if (we_q == WE_READ) begin
               rdata_d = finish_ok ? bus_io.mem_rdata : '0;
            end
         end
      end

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            ack_q   <= 1'b0;
            rdata_q <= '0;
         end else begin
            ack_q   <= ack_d;
            rdata_q <= rdata_d;
         end
      end

      assign port_ack[gi]   = ack_q;
      assign port_rdata[gi] = rdata_q;
   end

   // ------------------------------------------------------------- outputs
   assign bus_io.if_ack    = port_ack[ARB_PORT_IF];
   assign bus_io.if_rdata  = port_rdata[ARB_PORT_IF];
   assign bus_io.dm_ack    = port_ack[ARB_PORT_DM];
   assign bus_io.dm_rdata  = port_rdata[ARB_PORT_DM];
   assign bus_io.bus_err   = err_q;
   assign bus_io.mem_req   = mem_req_q;
   assign bus_io.mem_addr  = addr_q;
   assign bus_io.mem_wdata = wdata_q;
   assign bus_io.mem_we    = we_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_bus_arbiter
//   Directed bench for mem_bus_arbiter. Inputs change on the falling edge,
//   outputs are sampled on the falling edge, so each tick() advances exactly
//   one rising edge. "Cycle 0" is the cycle in which IDLE sees the request.
// -----------------------------------------------------------------------------
module tb_mem_bus_arbiter;
   import mem_bus_arbiter_pkg::*;

   logic clk;
   logic rst_n;

   int n_checks = 0;
   int n_pass   = 0;
   int n_fail   = 0;

   mem_bus_arbiter_if bus ();

   mem_bus_arbiter #(
      .TIMEOUT_CYC   (64),
      .DM_STREAK_MAX (4)
   ) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .bus_io (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic log_txn(input string port, input logic [AWIDTH-1:0] addr,
                          input logic [XLEN-1:0] data, input logic err);
      $display("txn %s addr=%03h data=%08h err=%0d", port, addr, data, err);
   endtask

   // Called in a BUSY cycle: stall 'waits' cycles, then complete with rd.
   // Returns at the falling edge of the DONE cycle.
   task automatic serve(input int waits, input logic [XLEN-1:0] rd);
      for (int i = 0; i < waits; i++) tick();
      bus.mem_ready = 1'b1;
      bus.mem_rdata = rd;
      tick();
      bus.mem_ready = 1'b0;
      bus.mem_rdata = '0;
   endtask

   initial begin
      rst_n         = 1'b0;
      bus.if_req    = 1'b0;
      bus.if_addr   = '0;
      bus.dm_req    = 1'b0;
      bus.dm_addr   = '0;
      bus.dm_wdata  = '0;
      bus.dm_we     = 3'b000;
      bus.mem_rdata = '0;
      bus.mem_ready = 1'b0;
      repeat (2) @(negedge clk);

      // ---- reset state
      check("rst_mem_req",  bus.mem_req,   0);
      check("rst_if_ack",   bus.if_ack,    0);
      check("rst_dm_ack",   bus.dm_ack,    0);
      check("rst_bus_err",  bus.bus_err,   0);
      check("rst_if_rdata", bus.if_rdata,  0);
      check("rst_dm_rdata", bus.dm_rdata,  0);
      check("rst_mem_bus",  {bus.mem_we, bus.mem_addr, bus.mem_wdata}, 0);
      rst_n = 1'b1;
      tick();

      // ---- fetch only: req in cycle 0, ready in cycle 1, ack in cycle 2
      bus.if_req  = 1'b1;
      bus.if_addr = 12'h004;
      tick();
      check("f_mem_req",   bus.mem_req,  1);
      check("f_mem_addr",  bus.mem_addr, 12'h004);
      check("f_mem_we",    bus.mem_we,   0);
      check("f_ack_early", bus.if_ack,   0);
      serve(0, 32'h00500093);
      check("f_if_ack",    bus.if_ack,   1);
      check("f_if_rdata",  bus.if_rdata, 32'h00500093);
      check("f_dm_ack",    bus.dm_ack,   0);
      check("f_req_done",  bus.mem_req,  0);
      log_txn("IF", 12'h004, bus.if_rdata, bus.bus_err);
      bus.if_req = 1'b0;
      tick();
      check("f_ack_pulse", bus.if_ack,   0);
      check("f_rdata_hold", bus.if_rdata, 32'h00500093);

      // ---- async reset in the middle of BUSY
      bus.dm_req  = 1'b1;
      bus.dm_addr = 12'h020;
      bus.dm_we   = 3'b000;
      tick();
      check("r_busy", bus.mem_req, 1);
      bus.mem_ready = 1'b1;
      bus.mem_rdata = 32'hFFFF0000;
      #2 rst_n = 1'b0;
      #1;
      check("r_async_mem_req", bus.mem_req,  0);
      check("r_if_rdata_clr",  bus.if_rdata, 0);
      @(negedge clk);
      bus.dm_req    = 1'b0;
      bus.mem_ready = 1'b0;
      tick();
      check("r_no_ack", bus.dm_ack,   0);
      check("r_dm_rd",  bus.dm_rdata, 0);
      rst_n = 1'b1;
      tick();
      check("r_no_ack_after", bus.dm_ack, 0);
      bus.if_req  = 1'b1;
      bus.if_addr = 12'h010;
      tick();
      check("r_fetch_addr", bus.mem_addr, 12'h010);
      serve(0, 32'h12345678);
      check("r_fetch_ack",   bus.if_ack,   1);
      check("r_fetch_rdata", bus.if_rdata, 32'h12345678);
      log_txn("IF", 12'h010, bus.if_rdata, bus.bus_err);
      bus.if_req = 1'b0;
      tick();

      // ---- plain data read (gives dm_rdata a known nonzero value)
      bus.dm_req  = 1'b1;
      bus.dm_addr = 12'h040;
      bus.dm_we   = 3'b000;
      tick();
      check("d_mem_addr", bus.mem_addr, 12'h040);
      serve(2, 32'hCAFEF00D);
      check("d_dm_ack",    bus.dm_ack,   1);
      check("d_dm_rdata",  bus.dm_rdata, 32'hCAFEF00D);
      check("d_if_rdata_own", bus.if_rdata, 32'h12345678);
      log_txn("DM", 12'h040, bus.dm_rdata, bus.bus_err);
      bus.dm_req = 1'b0;
      tick();

      // ---- collision: data write first, then fetch
      bus.if_req   = 1'b1;
      bus.if_addr  = 12'h008;
      bus.dm_req   = 1'b1;
      bus.dm_addr  = 12'h100;
      bus.dm_we    = 3'b111;
      bus.dm_wdata = 32'hDEADBEEF;
      tick();
      check("c_data_first", {bus.mem_we, bus.mem_addr, bus.mem_wdata},
            {3'b111, 12'h100, 32'hDEADBEEF});
      serve(0, 32'h11111111);
      check("c_dm_ack",     bus.dm_ack,   1);
      check("c_if_wait",    bus.if_ack,   0);
      check("c_wr_rdata",   bus.dm_rdata, 32'hCAFEF00D);
      check("c_wr_err",     bus.bus_err,  0);
      log_txn("DM", 12'h100, 32'hDEADBEEF, bus.bus_err);
      bus.dm_req = 1'b0;
      bus.dm_we  = 3'b000;
      tick();
      check("c_idle_gap", bus.mem_req, 0);
      tick();
      check("c_fetch_next", {bus.mem_we, bus.mem_addr}, {3'b000, 12'h008});
      serve(0, 32'hAAAA0001);
      check("c_if_ack",   bus.if_ack,   1);
      check("c_if_rdata", bus.if_rdata, 32'hAAAA0001);
      log_txn("IF", 12'h008, bus.if_rdata, bus.bus_err);
      bus.if_req = 1'b0;
      tick();

      // ---- starvation: four data grants, then fetch gets the fifth
      bus.if_req  = 1'b1;
      bus.if_addr = 12'h00C;
      bus.dm_req  = 1'b1;
      bus.dm_we   = 3'b000;
      bus.dm_addr = 12'h200;
      for (int k = 0; k < 4; k++) begin
         tick();
         check("s_data_grant", bus.mem_addr, 64'(12'h200 + 12'(4 * k)));
         serve(0, 32'hB0000000 + 32'(k));
         check("s_dm_ack",   bus.dm_ack,   1);
         check("s_dm_rdata", bus.dm_rdata, 64'(32'hB0000000 + 32'(k)));
         log_txn("DM", bus.mem_addr, bus.dm_rdata, bus.bus_err);
         bus.dm_addr = 12'h200 + 12'(4 * (k + 1));
         tick();
      end
      tick();
      check("s_fetch_grant", {bus.mem_we, bus.mem_addr}, {3'b000, 12'h00C});
      serve(0, 32'h0000A00C);
      check("s_if_ack",   bus.if_ack,   1);
      check("s_dm_wait",  bus.dm_ack,   0);
      check("s_if_rdata", bus.if_rdata, 32'h0000A00C);
      log_txn("IF", 12'h00C, bus.if_rdata, bus.bus_err);
      bus.if_req = 1'b0;
      tick();
      tick();
      check("s_data_resume", bus.mem_addr, 12'h210);
      serve(0, 32'hB0000004);
      check("s_resume_ack", bus.dm_ack, 1);
      log_txn("DM", 12'h210, bus.dm_rdata, bus.bus_err);
      bus.dm_req = 1'b0;
      tick();

      // ---- timeout: no mem_ready, ack in cycle 65 with bus_err and rdata=0
      bus.dm_req  = 1'b1;
      bus.dm_addr = 12'h300;
      bus.dm_we   = 3'b000;
      tick();
      repeat (63) tick();
      check("t_no_ack_64", bus.dm_ack,  0);
      check("t_busy_64",   bus.mem_req, 1);
      tick();
      check("t_ack_65",    bus.dm_ack,   1);
      check("t_bus_err",   bus.bus_err,  1);
      check("t_rdata_0",   bus.dm_rdata, 0);
      log_txn("DM", 12'h300, bus.dm_rdata, bus.bus_err);
      bus.dm_req = 1'b0;
      tick();
      check("t_err_pulse", bus.bus_err, 0);

      // ---- mem_ready on the terminal cycle counts as success
      bus.if_req  = 1'b1;
      bus.if_addr = 12'h014;
      tick();
      repeat (63) tick();
      bus.mem_ready = 1'b1;
      bus.mem_rdata = 32'h0BADC0DE;
      tick();
      bus.mem_ready = 1'b0;
      check("tt_if_ack",   bus.if_ack,   1);
      check("tt_no_err",   bus.bus_err,  0);
      check("tt_if_rdata", bus.if_rdata, 32'h0BADC0DE);
      log_txn("IF", 12'h014, bus.if_rdata, bus.bus_err);
      bus.if_req = 1'b0;
      tick();

      // ---- wait states on a write: bus stable, single ack, rdata untouched
      bus.dm_req   = 1'b1;
      bus.dm_addr  = 12'h0A0;
      bus.dm_we    = 3'b010;
      bus.dm_wdata = 32'h01234567;
      tick();
      for (int w = 0; w < 3; w++) begin
         check("w_stable", {bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_wdata},
               {1'b1, 3'b010, 12'h0A0, 32'h01234567});
         check("w_no_ack", bus.dm_ack, 0);
         tick();
      end
      bus.mem_ready = 1'b1;
      bus.mem_rdata = 32'h55555555;
      tick();
      bus.mem_ready = 1'b0;
      check("w_ack",        bus.dm_ack,   1);
      check("w_no_err",     bus.bus_err,  0);
      check("w_rdata_keep", bus.dm_rdata, 0);
      log_txn("DM", 12'h0A0, 32'h01234567, bus.bus_err);
      bus.dm_req = 1'b0;
      tick();
      check("w_single_ack", bus.dm_ack, 0);

      // ---- stray mem_ready while idle is ignored
      bus.mem_ready = 1'b1;
      tick();
      tick();
      check("i_idle_ready", {bus.mem_req, bus.if_ack, bus.dm_ack, bus.bus_err}, 0);
      bus.mem_ready = 1'b0;
      tick();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
